// File: rtl/rc_pkg.sv
// rtl/rc_pkg.sv - shared constants, state type and raw-value helper for the RC PWM channel decoder
package rc_pkg;

    localparam int MIN_TICKS = 40;
    localparam int SPAN      = 40;
    localparam int REJ_LO    = 32;
    localparam int REJ_HI    = 88;

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        IDLE     = 2'd1,
        MEASURE  = 2'd2
    } rc_state_e;

    // Width in ticks to stick position 0..SPAN, clamped at both ends.
    function automatic logic [7:0] rc_raw(input logic [7:0] w);
        logic [7:0] d;
        d = w - 8'(MIN_TICKS);
        if (w < 8'(MIN_TICKS)) begin
            return 8'd0;
        end else if (d > 8'(SPAN)) begin
            return 8'(SPAN);
        end else begin
            return d;
        end
    endfunction

endpackage

// File: rtl/rc_tick_prescaler.sv
// rtl/rc_tick_prescaler.sv - CLK_DIV cycle prescaler with synchronous clear and one-cycle tick
module rc_tick_prescaler #(
    parameter int CLK_DIV = 1250
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_tick = w_last && !i_clr;

endmodule

// File: rtl/rc_pwm_channel_decoder.sv
// rtl/rc_pwm_channel_decoder.sv - RC receiver pulse-width decoder with timeout failsafe
// Optional output averaging with the previous accepted value: RC_DECODER_AVG_EN.
module rc_pwm_channel_decoder
    import rc_pkg::*;
#(
    parameter int CLK_DIV        = 1250,
    parameter int FAILSAFE_VALUE = 20,
    parameter int TIMEOUT_TICKS  = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pwm_in,
    output logic [7:0] stick_value,
    output logic       value_valid,
    output logic       signal_lost
);

    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [7:0] FAILSAFE = 8'(FAILSAFE_VALUE);

    // Synchronizer resets high so a pulse in progress at reset looks like one that already started.
    logic r_sync1, r_sync2, r_sync_d;
    logic w_rise, w_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_sync_d <= 1'b1;
        end else begin
            r_sync1  <= pwm_in;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    assign w_rise = r_sync2 && !r_sync_d;
    assign w_fall = !r_sync2 && r_sync_d;

    rc_state_e r_state, w_state_next;
    logic      w_clr_presc;
    logic      w_eval;
    logic      w_tick;

    rc_tick_prescaler #(
        .CLK_DIV(CLK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_clr_presc),
        .o_tick(w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WAIT_LOW;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_clr_presc  = 1'b0;
        w_eval       = 1'b0;
        case (r_state)
            WAIT_LOW: begin
                if (!r_sync2) begin
                    w_state_next = IDLE;
                end
            end
            IDLE: begin
                if (w_rise) begin
                    w_state_next = MEASURE;
                    w_clr_presc  = 1'b1;
                end
            end
            MEASURE: begin
                if (w_fall) begin
                    w_state_next = IDLE;
                    w_eval       = 1'b1;
                end
            end
            default: w_state_next = WAIT_LOW;
        endcase
    end

    logic [7:0] r_width;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_width <= 8'd0;
        end else if (w_clr_presc) begin
            r_width <= 8'd0;
        end else if (r_state == MEASURE && w_tick && r_width != 8'hFF) begin
            r_width <= r_width + 8'd1;
        end
    end

    logic       w_accept;
    logic [7:0] w_raw;
    logic [7:0] w_out;
    logic       w_timeout_hit;
    logic [TW-1:0] r_timeout;

    assign w_accept      = w_eval && (r_width >= 8'(REJ_LO)) && (r_width <= 8'(REJ_HI));
    assign w_raw         = rc_raw(r_width);
    assign w_timeout_hit = w_tick && (r_timeout == TW'(TIMEOUT_TICKS - 1));

    // Counter parks at TIMEOUT_TICKS so the failsafe event fires once per loss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timeout <= '0;
        end else if (w_accept) begin
            r_timeout <= '0;
        end else if (w_tick && r_timeout != TW'(TIMEOUT_TICKS)) begin
            r_timeout <= r_timeout + TW'(1);
        end
    end

`ifdef RC_DECODER_AVG_EN
    logic [7:0] r_prev_raw;
    logic [8:0] w_sum;

    assign w_sum = {1'b0, w_raw} + {1'b0, r_prev_raw};
    assign w_out = w_sum[8:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_raw <= FAILSAFE;
        end else if (w_accept) begin
            r_prev_raw <= w_raw;
        end else if (w_timeout_hit) begin
            r_prev_raw <= FAILSAFE;
        end
    end
`else
    assign w_out = w_raw;
`endif

    logic [7:0] r_stick;
    logic       r_valid;
    logic       r_lost;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stick <= FAILSAFE;
            r_valid <= 1'b0;
            r_lost  <= 1'b1;
        end else begin
            r_valid <= w_accept;
            if (w_accept) begin
                r_stick <= w_out;
                r_lost  <= 1'b0;
            end else if (w_timeout_hit) begin
                r_stick <= FAILSAFE;
                r_lost  <= 1'b1;
            end
        end
    end

    assign stick_value = r_stick;
    assign value_valid = r_valid;
    assign signal_lost = r_lost;

endmodule

// File: tb/tb_rc_pwm_channel_decoder.sv
// tb/tb_rc_pwm_channel_decoder.sv - directed self-checking bench for rc_pwm_channel_decoder
module tb_rc_pwm_channel_decoder;

    localparam int DIV = 4;

    logic       clk;
    logic       rst_n;
    logic       pwm_in;
    logic [7:0] stick_value;
    logic       value_valid;
    logic       signal_lost;

    int tests;
    int fails;
    int strobes;

    rc_pwm_channel_decoder #(
        .CLK_DIV       (DIV),
        .FAILSAFE_VALUE(20),
        .TIMEOUT_TICKS (1000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwm_in     (pwm_in),
        .stick_value(stick_value),
        .value_valid(value_valid),
        .signal_lost(signal_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (value_valid === 1'b1) strobes++;
    end

    task automatic chk(input string tag, input int observed, input int expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // High for ticks*DIV+2 cycles; samples valid/lost at the expected strobe cycle and one after.
    task automatic do_pulse(input int ticks, output int v_at, output int lost_at,
                            output int v_after, output int nstrobe);
        int s0;
        s0 = strobes;
        pwm_in = 1'b1;
        repeat (ticks * DIV + 2) @(posedge clk);
        #1 pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        v_at    = int'(value_valid);
        lost_at = int'(signal_lost);
        @(posedge clk);
        #1 v_after = int'(value_valid);
        repeat (10) @(posedge clk);
        #1 nstrobe = strobes - s0;
    endtask

    int tk  [11] = '{60, 40, 80, 86, 36, 28, 100, 32, 88, 31, 89};
    int acc [11] = '{ 1,  1,  1,  1,  1,  0,   0,  1,  1,  0,  0};
    int exps[11] = '{20,  0, 40, 40,  0,  0,   0,  0, 40, 40, 40};

    initial begin
        int v_at, lost_at, v_after, nst, s0;
        tests   = 0;
        fails   = 0;
        strobes = 0;
        pwm_in  = 1'b0;
        rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_stick", int'(stick_value), 20);
        chk("reset_valid", int'(value_valid), 0);
        chk("reset_lost", int'(signal_lost), 1);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            do_pulse(tk[i], v_at, lost_at, v_after, nst);
            chk($sformatf("valid_latency_%0d", tk[i]), v_at, acc[i]);
            chk($sformatf("strobe_width_%0d", tk[i]), v_after, 0);
            chk($sformatf("strobe_count_%0d", tk[i]), nst, acc[i]);
            chk($sformatf("stick_%0d", tk[i]), int'(stick_value), exps[i]);
            if (i == 0) chk("lost_clear_with_valid", lost_at, 0);
        end
        chk("lost_after_table", int'(signal_lost), 0);

        do_pulse(80, v_at, lost_at, v_after, nst);
        chk("pre_timeout_stick", int'(stick_value), 40);
        s0 = strobes;
        repeat (3900) @(posedge clk);
        #1 chk("lost_before_timeout", int'(signal_lost), 0);
        repeat (250) @(posedge clk);
        #1;
        chk("lost_after_timeout", int'(signal_lost), 1);
        chk("failsafe_stick", int'(stick_value), 20);
        chk("timeout_no_strobe", strobes - s0, 0);

        do_pulse(50, v_at, lost_at, v_after, nst);
        chk("recover_valid", v_at, 1);
        chk("recover_lost_same_cycle", lost_at, 0);
        chk("recover_stick", int'(stick_value), 10);

        pwm_in = 1'b1;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rereset_stick", int'(stick_value), 20);
        chk("rereset_lost", int'(signal_lost), 1);
        s0 = strobes;
        rst_n = 1'b1;
        repeat (40 * DIV) @(posedge clk);
        #1 pwm_in = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("inflight_no_strobe", strobes - s0, 0);
        chk("inflight_stick", int'(stick_value), 20);
        do_pulse(60, v_at, lost_at, v_after, nst);
        chk("post_reset_valid", v_at, 1);
        chk("post_reset_count", nst, 1);
        chk("post_reset_stick", int'(stick_value), 20);
        chk("post_reset_lost", int'(signal_lost), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rc_pwm_channel_decoder.md
RC_PWM_CHANNEL_DECODER -- requirements
Module: rc_pwm_channel_decoder

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 1250, meaning clk cycles per 25 us tick (50 MHz clock).
REQ-002 The block SHALL have parameter FAILSAFE_VALUE, default 20, meaning the stick value driven while the signal is lost (stick centre).
REQ-003 The block SHALL have parameter TIMEOUT_TICKS, default 1000, meaning ticks without an accepted pulse before signal loss (25 ms).
REQ-004 The block SHALL use one clock, clk; reset is rst_n, asynchronous and active-low.
REQ-005 Port clk, input, 1 bit: system clock.
REQ-006 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 Port pwm_in, input, 1 bit: asynchronous RC receiver channel pulse, nominally 1000-2000 us high.
REQ-008 Port stick_value, output, 8 bits: decoded stick position, 0..40, feeding the offset generators.
REQ-009 Port value_valid, output, 1 bit: one-cycle strobe, high when stick_value updates from an accepted pulse.
REQ-010 Port signal_lost, output, 1 bit: level, high while no valid pulse has been received within the timeout.

Function
REQ-011 pwm_in SHALL pass through a 2-FF synchronizer; all edge detection SHALL use the synchronized signal.
REQ-012 The state machine SHALL have the states WAIT_LOW, IDLE and MEASURE.
REQ-013 WAIT_LOW -> IDLE when the synchronized input is low; this SHALL be the reset state, so a pulse already in progress at reset is never measured.
REQ-014 IDLE -> MEASURE on a rising edge; the tick prescaler and the 8-bit width counter SHALL clear on that edge.
REQ-015 In MEASURE the width counter SHALL increment once per completed tick and SHALL saturate at 255.
REQ-016 MEASURE -> IDLE on a falling edge; the width w is then evaluated.
REQ-017 If 32 <= w <= 88 (800-2200 us), the pulse SHALL be accepted and raw = clamp(w - 40, 0, 40); otherwise the pulse SHALL be rejected with no output change and no strobe.
REQ-018 Latency: stick_value and value_valid SHALL update on the clock edge after the cycle in which the falling edge is detected.
REQ-019 The prescaler SHALL otherwise free-run; the timeout counter SHALL count ticks and clear on every accepted pulse.
REQ-020 When the timeout counter reaches TIMEOUT_TICKS, signal_lost SHALL be set and stick_value SHALL be forced to FAILSAFE_VALUE without a value_valid strobe.
REQ-021 signal_lost SHALL clear on the next accepted pulse, in the same cycle as its value_valid.
REQ-022 If acceptance and timeout occur in the same cycle, acceptance SHALL win.
REQ-023 Arithmetic SHALL be subtraction and compare only; no multipliers or dividers.

Reset
REQ-024 On reset assertion, regardless of the current state: stick_value = FAILSAFE_VALUE, value_valid = 0, signal_lost = 1, state = WAIT_LOW, all counters = 0.

Configuration
REQ-025 With macro RC_DECODER_AVG_EN defined, the output on acceptance SHALL be (raw + prev_raw) >> 1, computed in 9 bits and truncated. prev_raw SHALL hold the last accepted raw value and SHALL be reset to FAILSAFE_VALUE on reset and on signal loss.
REQ-026 Without RC_DECODER_AVG_EN, the output on acceptance SHALL equal raw, and no prev_raw register SHALL exist.

Structure
REQ-027 Package rc_pkg SHALL hold MIN_TICKS=40, SPAN=40, REJ_LO=32, REJ_HI=88 and the state enum typedef.
REQ-028 Sub-module rc_tick_prescaler (CLK_DIV counter, synchronous clear, one-cycle tick output) SHALL be instantiated once.

Verification
REQ-029 1500 us high pulse -> one value_valid strobe, stick_value=20.
REQ-030 1000 us pulse -> 0; 2000 us pulse -> 40; 2150 us pulse -> 40 (clamped); 900 us pulse -> 0 (clamped).
REQ-031 700 us pulse and 2500 us pulse -> no strobe, stick_value unchanged.
REQ-032 Input high when reset deasserts, then a 1500 us pulse -> first pulse ignored, second pulse gives 20.
REQ-033 Valid pulses, then input idle for 25 ms -> signal_lost=1, stick_value=20; next 1250 us pulse -> signal_lost=0, stick_value=10.
REQ-034 With RC_DECODER_AVG_EN, 1000 us then 2000 us pulses after reset -> outputs 10 then 20.
